// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I main control FSM (optional memory timeout: MULTICYCLE_TIMEOUT_EN)
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       op_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             branch_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_R      = 3'd1,
    C_I      = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             timed_out;
  logic             retire;

  // Map an opcode to its instruction class; C_NONE marks an illegal opcode.
  function automatic cls_t decode_op(input logic [6:0] op);
    case (op)
      7'b0110011: decode_op = C_R;
      7'b0010011: decode_op = C_I;
      7'b0000011: decode_op = C_LOAD;
      7'b0100011: decode_op = C_STORE;
      7'b1100011: decode_op = C_BRANCH;
      default:    decode_op = C_NONE;
    endcase
  endfunction

`ifdef MULTICYCLE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              waiting;

  // Count consecutive cycles spent waiting on memory; any other cycle clears it,
  // so the count always starts at zero on entry to FETCH or MEM.
  always_comb begin
    waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i;
    timed_out = waiting && (wait_q == WAIT_W'(TIMEOUT - 1));
    wait_d    = '0;
    timeout_d = timeout_q;
    if (waiting && !timed_out) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    if (timed_out) begin
      timeout_d = 1'b1;
    end
  end

  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT < 1);
  assign timed_out      = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  // Next-state, strobes and ALU controls; memory completion in FETCH is Mealy.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    illegal_d  = illegal_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    branch_o   = 1'b0;
    ALUOp_o    = 2'b00;
    ALUSrc_o   = 1'b0;
    RegWrite_o = 1'b0;
    MemToReg_o = 1'b0;

    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      case (cls_q)
        C_R:              begin ALUOp_o = 2'b01; ALUSrc_o = 1'b0; end
        C_I:              begin ALUOp_o = 2'b00; ALUSrc_o = 1'b1; end
        C_LOAD, C_STORE:  begin ALUOp_o = 2'b10; ALUSrc_o = 1'b1; end
        C_BRANCH:         begin ALUOp_o = 2'b11; ALUSrc_o = 1'b0; end
        default:          begin ALUOp_o = 2'b00; ALUSrc_o = 1'b0; end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        cls_d = decode_op(op_i);
        if (decode_op(op_i) == C_NONE) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R, C_I:        state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            branch_o = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default:         state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cls_q == C_STORE);
        if (mem_ready_i) begin
          if (cls_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        MemToReg_o = (cls_q == C_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // State, latched class, sticky illegal flag and retired counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (honours MULTICYCLE_TIMEOUT_EN)
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [6:0]    op_i = 7'd0;
  logic          mem_ready_i = 1'b0;
  logic          mem_req_o, mem_we_o, ir_write_o, pc_write_o, branch_o;
  logic [1:0]    ALUOp_o;
  logic          ALUSrc_o, RegWrite_o, MemToReg_o, illegal_o, timeout_o;
  logic [2:0]    state_o;
  logic [CW-1:0] retired_o;

  multicycle_control #(.TIMEOUT(15), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .branch_o(branch_o),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
    .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
  localparam logic [6:0] Z = 7'd0;

  typedef struct {
    string       nm;
    logic [18:0] e;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_x;
  int            checks = 0;
  int            failures = 0;
  logic          exp_ill = 1'b0;
  logic          exp_to = 1'b0;
  logic [CW-1:0] exp_ret = '0;
  logic [18:0]   act;

  assign act = {state_o, mem_req_o, mem_we_o, ir_write_o, pc_write_o, branch_o,
                ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, illegal_o, timeout_o, retired_o};

  // Monitor: every expected record queued for a cycle is compared mid-cycle.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      checks++;
      if (act !== mon_x.e) begin
        failures++;
        $display("FAIL %s act=%b exp=%b (st,req,we,ir,pc,br,aop,asrc,rw,m2r,ill,to,ret)",
                 mon_x.nm, act, mon_x.e);
      end
    end
  end

  function automatic logic [18:0] ev(input logic [2:0] st, input logic req, we, ir, pc, br,
                                     input logic [1:0] aop, input logic asrc, rw, m2r);
    return {st, req, we, ir, pc, br, aop, asrc, rw, m2r, exp_ill, exp_to, exp_ret};
  endfunction

  task automatic step(input string nm, input logic r, s, input logic [6:0] op,
                      input logic rdy, input logic chk, input logic [18:0] e);
    rst_i = r; start_i = s; op_i = op; mem_ready_i = rdy;
    if (chk) sb_q.push_back('{nm, e});
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    step("rst", 1'b1, 1'b0, Z, 1'b0, 1'b0, '0);
    exp_ret = '0; exp_ill = 1'b0; exp_to = 1'b0;
  endtask

  initial begin
    @(posedge clk_i); #1;
    step("reset_hold", 1, 0, Z, 1, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    // R-type, zero-wait fetch
    step("r_idle",   0, 1, Z,    0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    step("r_fetch",  0, 0, Z,    1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("r_decode", 0, 0, OP_R, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("r_exec",   0, 0, Z,    0, 1, ev(3, 0,0,0,0,0, 2'b01, 0,0,0));
    step("r_wb",     0, 0, Z,    0, 1, ev(5, 0,0,0,0,0, 2'b01, 0,1,0));
    exp_ret = 4'd1;
    // I-type
    step("i_fetch",  0, 0, Z,    1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("i_decode", 0, 0, OP_I, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("i_exec",   0, 0, Z,    0, 1, ev(3, 0,0,0,0,0, 2'b00, 1,0,0));
    step("i_wb",     0, 0, Z,    0, 1, ev(5, 0,0,0,0,0, 2'b00, 1,1,0));
    exp_ret = 4'd2;
    // LOAD with one fetch wait and three data waits
    step("ld_fwait", 0, 0, Z,     0, 1, ev(1, 1,0,0,0,0, 2'b00, 0,0,0));
    step("ld_fetch", 0, 0, Z,     1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("ld_dec",   0, 0, OP_LD, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("ld_exec",  0, 0, Z,     0, 1, ev(3, 0,0,0,0,0, 2'b10, 1,0,0));
    for (int i = 0; i < 3; i++)
      step("ld_mwait", 0, 0, Z,   0, 1, ev(4, 1,0,0,0,0, 2'b10, 1,0,0));
    step("ld_mem",   0, 0, Z,     1, 1, ev(4, 1,0,0,0,0, 2'b10, 1,0,0));
    step("ld_wb",    0, 0, Z,     0, 1, ev(5, 0,0,0,0,0, 2'b10, 1,1,1));
    exp_ret = 4'd3;
    // STORE then BRANCH
    step("st_fetch", 0, 0, Z,     1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("st_dec",   0, 0, OP_ST, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("st_exec",  0, 0, Z,     0, 1, ev(3, 0,0,0,0,0, 2'b10, 1,0,0));
    step("st_mem",   0, 0, Z,     1, 1, ev(4, 1,1,0,0,0, 2'b10, 1,0,0));
    exp_ret = 4'd4;
    step("br_fetch", 0, 0, Z,     1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("br_dec",   0, 0, OP_BR, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("br_exec",  0, 0, Z,     0, 1, ev(3, 0,0,0,0,1, 2'b11, 0,0,0));
    exp_ret = 4'd5;
    // Reset in the middle of a LOAD data wait
    step("ab_fetch", 0, 0, Z,     1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("ab_dec",   0, 0, OP_LD, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    step("ab_exec",  0, 0, Z,     0, 1, ev(3, 0,0,0,0,0, 2'b10, 1,0,0));
    step("ab_mwait", 0, 0, Z,     0, 1, ev(4, 1,0,0,0,0, 2'b10, 1,0,0));
    do_reset();
    step("ab_idle",  0, 0, Z,     1, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    // Sixteen branches: counter runs 0..15 and wraps to 0
    step("wr_idle",  0, 1, Z,     0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    for (int i = 0; i < 16; i++) begin
      step("wr_fetch", 0, 0, Z,     1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
      step("wr_dec",   0, 0, OP_BR, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
      step("wr_exec",  0, 0, Z,     0, 1, ev(3, 0,0,0,0,1, 2'b11, 0,0,0));
      exp_ret = exp_ret + 4'd1;
    end
    step("wr_zero",  0, 0, Z,     0, 1, ev(1, 1,0,0,0,0, 2'b00, 0,0,0));
    // Illegal opcode traps and holds until reset
    step("il_fetch", 0, 0, Z,      1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("il_dec",   0, 0, OP_BAD, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    exp_ill = 1'b1;
    for (int i = 0; i < 4; i++)
      step("il_trap", 0, i[0], OP_R, ~i[0], 1, ev(6, 0,0,0,0,0, 2'b00, 0,0,0));
    do_reset();
    step("il_clear", 0, 0, Z,      0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
`ifdef MULTICYCLE_TIMEOUT_EN
    // Ready in the final allowed cycle beats the timeout
    step("to_idle",  0, 1, Z, 0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    for (int i = 0; i < 14; i++)
      step("to_wait", 0, 0, Z, 0, 1, ev(1, 1,0,0,0,0, 2'b00, 0,0,0));
    step("to_last_ready", 0, 0, Z, 1, 1, ev(1, 1,0,1,1,0, 2'b00, 0,0,0));
    step("to_dec", 0, 0, OP_I, 0, 1, ev(2, 0,0,0,0,0, 2'b00, 0,0,0));
    do_reset();
    // Fifteen waiting cycles trap
    step("tt_idle",  0, 1, Z, 0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    for (int i = 0; i < 15; i++)
      step("tt_wait", 0, 0, Z, 0, 1, ev(1, 1,0,0,0,0, 2'b00, 0,0,0));
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++)
      step("tt_trap", 0, 1, Z, 1, 1, ev(6, 0,0,0,0,0, 2'b00, 0,0,0));
`else
    // Without the timeout, FETCH waits indefinitely
    step("nt_idle",  0, 1, Z, 0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    for (int i = 0; i < 100; i++)
      step("nt_wait", 0, 0, Z, 0, 1, ev(1, 1,0,0,0,0, 2'b00, 0,0,0));
`endif
    do_reset();
    step("final_idle", 0, 0, Z, 0, 1, ev(0, 0,0,0,0,0, 2'b00, 0,0,0));
    @(negedge clk_i); #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain act=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the RV32I datapath; the next generation of the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, handshakes with instruction/data memory, and traps on illegal opcodes or memory timeouts. Sits between the instruction register and the datapath write enables, with a retired-instruction counter for bring-up.

## Interface
- TIMEOUT, 15: max cycles waiting for `mem_ready_i` in FETCH or MEM before trapping (≥1).
- CNT_W, 16: width of retired-instruction counter.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  leave IDLE; sampled only in IDLE.
- op_i  input  7  opcode from instruction register; sampled only in DECODE.
- mem_ready_i  input  1  memory completes the current request; ignored outside FETCH/MEM.
- mem_req_o  output  1  memory request (instruction in FETCH, data in MEM).
- mem_we_o  output  1  data write (store in MEM).
- ir_write_o  output  1  load instruction register.
- pc_write_o  output  1  PC ← PC+4.
- branch_o  output  1  branch resolution strobe.
- ALUOp_o  output  2  00 I-type, 01 R-type, 10 address add, 11 compare.
- ALUSrc_o  output  1  1 = immediate operand.
- RegWrite_o  output  1  register file write.
- MemToReg_o  output  1  write-back from memory data.
- illegal_o  output  1  sticky: illegal opcode trap.
- timeout_o  output  1  sticky: memory timeout trap.
- state_o  output  3  current state encoding.
- retired_o  output  CNT_W  completed-instruction count.

## Operation
- Opcode classes (latched in DECODE): R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011; anything else illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 unreachable, recovers to IDLE.
- IDLE: start_i=1 → FETCH.
- FETCH: mem_req_o=1; when mem_ready_i=1, ir_write_o=pc_write_o=1 that same cycle (Mealy) → DECODE; else stay.
- DECODE: illegal → TRAP with illegal_o set; else → EXEC.
- EXEC: R/I → WB; LOAD/STORE → MEM; BRANCH: branch_o=1 one cycle, retire → FETCH.
- MEM: mem_req_o=1, mem_we_o=1 for STORE; on mem_ready_i: LOAD → WB, STORE retire → FETCH.
- WB: RegWrite_o=1 one cycle; MemToReg_o=1 for LOAD; retire → FETCH.
- TRAP: all strobes 0; stays until rst_i.
- ALUOp_o/ALUSrc_o from latched class in EXEC/MEM/WB: R 01/0, I 00/1, LOAD/STORE 10/1, BRANCH 11/0; 00/0 elsewhere.
- retired_o +1 on each retire; wraps 2^CNT_W−1 → 0.

## Timing
- Reset: state IDLE; every output 0; class, counters, trap flags cleared. Reset mid-instruction aborts it with no further strobes.
- Zero-wait memory (ready in first FETCH/MEM cycle): BRANCH 3 cycles, R/I/STORE 4, LOAD 5, FETCH-entry to FETCH-entry.
- Each wait cycle adds one cycle; mem_req_o held high throughout the wait.
- mem_ready_i and completion of an instruction never overlap with start_i; start_i outside IDLE ignored.
- Write strobes are single-cycle; never asserted in IDLE, DECODE or TRAP.

## Configuration
- MULTICYCLE_TIMEOUT_EN defined: wait counter ($clog2(TIMEOUT+1) bits) cleared on entry to FETCH/MEM, increments per cycle without mem_ready_i; at TIMEOUT consecutive waiting cycles → TRAP with timeout_o=1, mem_req_o deasserted. mem_ready_i in the final cycle wins over timeout.
- Undefined: no counter, waits indefinitely; timeout_o tied 0.

## Test plan
- Reset, start_i, R-type 0110011, ready immediate → states 1,2,3,5,1; RegWrite_o one cycle in WB, ALUOp_o=01, ALUSrc_o=0, retired_o=1.
- LOAD 0000011, data ready after 3 waits → MEM 4 cycles, mem_we_o=0, then WB with MemToReg_o=1; total 8 cycles.
- STORE 0100011 then BRANCH 1100011 → mem_we_o=1 in MEM, no RegWrite_o; branch_o one cycle; retired_o=2.
- Opcode 1111111 → TRAP, illegal_o=1 held, no strobes; rst_i → IDLE, all outputs 0.
- With MULTICYCLE_TIMEOUT_EN, TIMEOUT=15, mem_ready_i never in FETCH → TRAP after 15 cycles, timeout_o=1; without macro still in FETCH after 100 cycles.
- CNT_W=4, 16 back-to-back branches → retired_o wraps 15 → 0; rst_i mid-MEM → IDLE next cycle, mem_req_o=0.
